demux_dispatch: RTL and testbench

//  Registered 1:4 stream dispatcher wrapping the 1:4 demux datapath.
//  - Accepts one beat per handshake on a single valid/ready input.
//  - Routes each beat to exactly one of four outputs, either by an explicit select or round-robin.
//  - Holds each beat until the chosen sink accepts it.
//  - Sits between a single producer and four consumer lanes.

---
 rtl/demux_dispatch_pkg.sv | 20 ++
 rtl/demux_dispatch_dec.sv | 19 +
 rtl/demux_dispatch.sv | 92 +++++++++
 tb/tb_demux_dispatch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_dispatch_pkg.sv
// Shared types and helpers for the 1:4 stream dispatcher.
// Optional statistics build: define DEMUX_DISPATCH_STATS_EN.
package demux_dispatch_pkg;

    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    function automatic logic [NUM_OUT-1:0] onehot4(input logic [SEL_W-1:0] sel);
        logic [NUM_OUT-1:0] r;
        r      = '0;
        r[sel] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/demux_dispatch_dec.sv
// 2->4 one-hot lane decoder with enable.
// All zeros when disabled so no lane sees a stray valid.
module demux_dec2_4
    import demux_dispatch_pkg::*;
(
    input  logic               i_en,
    input  logic [SEL_W-1:0]   i_sel,
    output logic [NUM_OUT-1:0] o_onehot
);

    // Decode the held destination into a one-hot lane valid.
    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot = onehot4(i_sel);
        end
    end

endmodule

// File: rtl/demux_dispatch.sv
// Registered 1:4 stream dispatcher (directed or round-robin).
// Optional per-lane drain counters: define DEMUX_DISPATCH_STATS_EN.
module demux_dispatch
    import demux_dispatch_pkg::*;
#(
    parameter int DATA_W = 8
`ifdef DEMUX_DISPATCH_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [NUM_OUT-1:0]       out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic [NUM_OUT-1:0]       out_ready
`ifdef DEMUX_DISPATCH_STATS_EN
    ,
    output logic [NUM_OUT*CNT_W-1:0] stat_cnt
`endif
);

    state_t            r_state;
    logic [SEL_W-1:0]  r_dest;
    logic [SEL_W-1:0]  r_rr_ptr;
    logic [DATA_W-1:0] r_data;

    logic w_hold;
    logic w_drain;
    logic w_accept;

    // Only the selected lane's ready can free the register.
    assign w_hold   = (r_state == HOLD);
    assign w_drain  = w_hold && out_ready[r_dest];
    assign in_ready = !rst && (!w_hold || out_ready[r_dest]);
    assign w_accept = in_valid && in_ready;
    assign out_data = r_data;

    // Output register FSM: load on accept, empty on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_dest   <= '0;
            r_rr_ptr <= '0;
            r_data   <= '0;
        end else if (w_accept) begin
            r_state <= HOLD;
            r_data  <= in_data;
            r_dest  <= mode ? r_rr_ptr : sel;
            if (mode) begin
                r_rr_ptr <= r_rr_ptr + 1'b1;
            end
        end else if (w_drain) begin
            r_state <= IDLE;
        end
    end

    demux_dec2_4 u_dec (
        .i_en     (w_hold),
        .i_sel    (r_dest),
        .o_onehot (out_valid)
    );

`ifdef DEMUX_DISPATCH_STATS_EN
    logic [CNT_W-1:0] r_cnt [NUM_OUT];

    // Saturating per-lane drain counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (w_drain && r_dest == SEL_W'(k) && r_cnt[k] != '1) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_stat
        assign stat_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
    end
`endif

endmodule

// File: tb/tb_demux_dispatch.sv
// Scoreboard bench for demux_dispatch.
// Define DEMUX_DISPATCH_STATS_EN to also exercise the counters.
module tb_demux_dispatch;

    localparam int DW = 8;
`ifdef DEMUX_DISPATCH_STATS_EN
    localparam int CW = 2;
`endif

    typedef struct {
        logic [1:0]    lane;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          mode = 1'b0;
    logic [1:0]    sel = '0;
    logic [3:0]    out_valid;
    logic [DW-1:0] out_data;
    logic [3:0]    out_ready = 4'b1111;
`ifdef DEMUX_DISPATCH_STATS_EN
    logic [4*CW-1:0] stat_cnt;
`endif

    int total = 0;
    int bad   = 0;

    beat_t q[$];
    beat_t dlog[$];
    logic [1:0] m_rr = '0;
    logic       rst_prev = 1'b0;

    always #5 clk = ~clk;

    demux_dispatch #(
        .DATA_W (DW)
`ifdef DEMUX_DISPATCH_STATS_EN
        ,
        .CNT_W  (CW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef DEMUX_DISPATCH_STATS_EN
        ,
        .stat_cnt  (stat_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] oh(input logic [1:0] s);
        logic [3:0] r;
        r    = '0;
        r[s] = 1'b1;
        return r;
    endfunction

    // Reference model, evaluated at negedge for the coming posedge.
    always @(negedge clk) begin
        logic  exp_rdy;
        logic  drain;
        beat_t b;
        if (rst) begin
            chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
            if (rst_prev) begin
                chk("rst_out_valid", {28'b0, out_valid}, 32'd0);
                chk("rst_out_data", {24'b0, out_data}, 32'd0);
            end
            q.delete();
            m_rr = '0;
        end else begin
            exp_rdy = (q.size() == 0) || out_ready[q[0].lane];
            chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
            if (q.size() == 0) begin
                chk("out_valid_idle", {28'b0, out_valid}, 32'd0);
                drain = 1'b0;
            end else begin
                chk("out_valid", {28'b0, out_valid}, {28'b0, oh(q[0].lane)});
                chk("out_data", {24'b0, out_data}, {24'b0, q[0].data});
                drain = out_ready[q[0].lane];
            end
            if (drain) begin
                dlog.push_back(q.pop_front());
            end
            if (in_valid && exp_rdy) begin
                b.lane = mode ? m_rr : sel;
                b.data = in_data;
                if (mode) m_rr = m_rr + 2'd1;
                q.push_back(b);
            end
        end
        rst_prev = rst;
    end

    task automatic send(input logic m, input logic [1:0] s,
                        input logic [DW-1:0] d);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        mode     = m;
        sel      = s;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mode     = 1'($urandom);
        sel      = 2'($urandom);
        in_data  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string tag, input logic [1:0] lane,
                           input logic [DW-1:0] data);
        beat_t b;
        if (dlog.size() == 0) begin
            chk({tag, "_missing"}, 32'd0, 32'd1);
        end else begin
            b = dlog.pop_front();
            chk({tag, "_lane"}, {30'b0, b.lane}, {30'b0, lane});
            chk({tag, "_data"}, {24'b0, b.data}, {24'b0, data});
        end
    endtask

    initial begin
        logic [1:0] rr_lanes [6];
        rr_lanes = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // 1: reset release
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("t1_ready", {31'b0, in_ready}, 32'd1);
        idle(1);

        // 2: directed
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 2'(i), 8'hA0 + 8'(i));
        end
        idle(2);
        for (int i = 0; i < 4; i++) begin
            chk_log("t2", 2'(i), 8'hA0 + 8'(i));
        end

        // 3: round-robin back-to-back
        for (int i = 0; i < 6; i++) begin
            send(1'b1, 2'(3 - (i % 4)), 8'hB0 + 8'(i));
        end
        idle(2);
        for (int i = 0; i < 6; i++) begin
            chk_log("t3", rr_lanes[i], 8'hB0 + 8'(i));
        end

        // 4: backpressure on lane 2
        out_ready = 4'b1011;
        send(1'b0, 2'd2, 8'h55);
        in_valid = 1'b1;
        mode     = 1'b0;
        sel      = 2'd0;
        in_data  = 8'h66;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_ready", {31'b0, in_ready}, 32'd0);
            chk("t4_valid", {28'b0, out_valid}, 32'h4);
            chk("t4_data", {24'b0, out_data}, 32'h55);
        end
        @(posedge clk);
        #1;
        out_ready = 4'b1111;
        @(negedge clk);
        chk("t4_release", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        idle(2);
        chk_log("t4a", 2'd2, 8'h55);
        chk_log("t4b", 2'd0, 8'h66);

        // 5: reset while holding
        out_ready = 4'b0000;
        send(1'b1, 2'd0, 8'h77);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        out_ready = 4'b1111;
        @(negedge clk);
        chk("t5_valid", {28'b0, out_valid}, 32'd0);
        idle(1);
        send(1'b1, 2'd3, 8'h88);
        idle(2);
        chk_log("t5", 2'd0, 8'h88);
        chk("t5_nolog", dlog.size(), 32'd0);

`ifdef DEMUX_DISPATCH_STATS_EN
        // 6: saturating counters
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);
        chk("t6_clr", {24'b0, stat_cnt}, 32'd0);
        send(1'b0, 2'd1, 8'h01);
        send(1'b0, 2'd1, 8'h02);
        idle(2);
        chk("t6_two", {24'b0, stat_cnt}, 32'h08);
        for (int i = 0; i < 3; i++) send(1'b0, 2'd1, 8'h10 + 8'(i));
        idle(2);
        chk("t6_sat", {24'b0, stat_cnt}, 32'h0C);
        dlog.delete();
`endif

        chk("q_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
